// File: rtl/nv_nvdla_glb_icx.sv
// Done-interrupt aggregator with mask / W1C status / software set registers
// and an event/timeout coalescing FSM driving a registered core interrupt.
module nv_nvdla_glb_icx #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic [2*NUM_CH-1:0]   done_intr_pd,
  input  logic                  reg_wr_en,
  input  logic                  reg_rd_en,
  input  logic [1:0]            reg_offset,
  input  logic [31:0]           reg_wr_data,
  output logic [31:0]           reg_rd_data,
  output logic                  reg_rd_valid,
  output logic                  core_intr
);

  localparam int unsigned NB = 2 * NUM_CH;

  localparam logic [1:0] OFF_MASK   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_SET    = 2'd2;
  localparam logic [1:0] OFF_COAL   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMR_ONE = TMO_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FIRE
  } state_t;

  logic [NB-1:0]    r_mask;
  logic [NB-1:0]    r_status;
  logic [CNT_W-1:0] r_thr;
  logic [TMO_W-1:0] r_tmo;
  state_t           r_state;
  logic [CNT_W-1:0] r_evt_cnt;
  logic [TMO_W-1:0] r_tmr;

  logic             w_wr_mask;
  logic             w_wr_status;
  logic             w_wr_set;
  logic             w_wr_coal;
  logic [NB-1:0]    w_wdata;
  logic [NB-1:0]    w_w1c;
  logic [NB-1:0]    w_set;
  logic [NB-1:0]    w_status_nxt;
  logic             w_evt;
  logic             w_pending;
  logic             w_thr_hit;
  logic             w_tmo_hit;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [TMO_W-1:0] w_tmr_inc;
  logic [TMO_W-1:0] w_tmr_entry;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_wr_mask   = reg_wr_en && (reg_offset == OFF_MASK);
  assign w_wr_status = reg_wr_en && (reg_offset == OFF_STATUS);
  assign w_wr_set    = reg_wr_en && (reg_offset == OFF_SET);
  assign w_wr_coal   = reg_wr_en && (reg_offset == OFF_COAL);

  assign w_wdata     = reg_wr_data[NB-1:0];
  assign w_w1c       = w_wr_status ? w_wdata : '0;
  assign w_set       = w_wr_set ? w_wdata : '0;

  // Sets (hardware or software) are OR-ed in after the clear, so a set wins
  // over a same-cycle W1C on the same bit.
  assign w_status_nxt = (r_status & ~w_w1c) | done_intr_pd | w_set;

  // An event is a cycle in which at least one unmasked status bit goes 0->1.
  assign w_evt       = |(w_status_nxt & ~r_status & ~r_mask);
  assign w_pending   = |(r_status & ~r_mask);

  assign w_thr_hit   = (r_evt_cnt >= r_thr);
  assign w_tmo_hit   = (r_tmo != '0) && (r_tmr == r_tmo);
  assign w_cnt_inc   = (r_evt_cnt == '1) ? r_evt_cnt : r_evt_cnt + CNT_ONE;
  assign w_tmr_inc   = (r_tmr >= r_tmo) ? r_tmo : r_tmr + TMR_ONE;

  // The timer holds the 1-based index of the current COLLECT cycle, so the
  // entry edge already counts the first one; this makes the timeout fire
  // exactly TMO cycles after COLLECT is entered.
  assign w_tmr_entry = (r_tmo != '0) ? TMR_ONE : '0;

  assign w_unused_wdata = ^reg_wr_data;

  // Software-visible registers: mask, status, coalescing threshold/timeout.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_mask   <= '1;
      r_status <= '0;
      r_thr    <= CNT_ONE;
      r_tmo    <= '0;
    end else begin
      r_status <= w_status_nxt;
      if (w_wr_mask) begin
        r_mask <= w_wdata;
      end
      if (w_wr_coal) begin
        r_thr <= reg_wr_data[CNT_W-1:0];
        r_tmo <= reg_wr_data[CNT_W+TMO_W-1:CNT_W];
      end
    end
  end

  // Coalescing FSM with event counter, timeout timer and registered interrupt.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state   <= ST_IDLE;
      r_evt_cnt <= '0;
      r_tmr     <= '0;
      core_intr <= 1'b0;
    end else if (!w_pending) begin
      // Returning to (or staying in) IDLE restarts the count, but an event
      // arriving on this very edge is kept so it is not lost.
      r_state   <= ST_IDLE;
      r_evt_cnt <= w_evt ? CNT_ONE : '0;
      r_tmr     <= '0;
      core_intr <= 1'b0;
    end else begin
      if (w_evt) begin
        r_evt_cnt <= w_cnt_inc;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_thr <= CNT_ONE) begin
            r_state   <= ST_FIRE;
            core_intr <= 1'b1;
          end else begin
            r_state <= ST_COLLECT;
            r_tmr   <= w_tmr_entry;
          end
        end
        ST_COLLECT: begin
          if (w_thr_hit || w_tmo_hit) begin
            r_state   <= ST_FIRE;
            core_intr <= 1'b1;
          end else begin
            r_tmr <= w_tmr_inc;
          end
        end
        ST_FIRE: begin
          core_intr <= 1'b1;
        end
        default: begin
          r_state   <= ST_IDLE;
          core_intr <= 1'b0;
        end
      endcase
    end
  end

  // Read mux over pre-write register values.
  always_comb begin
    w_rd_mux = '0;
    case (reg_offset)
      OFF_MASK:   w_rd_mux[NB-1:0] = r_mask;
      OFF_STATUS: w_rd_mux[NB-1:0] = r_status;
      OFF_COAL:   w_rd_mux[CNT_W+TMO_W-1:0] = {r_tmo, r_thr};
      default:    w_rd_mux = '0;
    endcase
  end

  // Registered read response, valid one cycle after the strobe.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      reg_rd_data  <= '0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en) begin
        reg_rd_data <= w_rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_nv_nvdla_glb_icx.sv
// Self-checking bench for nv_nvdla_glb_icx: register vectors, directed
// coalescing sequences, parameter builds and a randomized model comparison.
module tb_nv_nvdla_glb_icx;

  localparam logic [1:0] MASK   = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;
  localparam logic [1:0] SET    = 2'd2;
  localparam logic [1:0] COAL   = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;

  logic [15:0] pd;
  logic        wr_en, rd_en;
  logic [1:0]  off;
  logic [31:0] wdata, rd_data;
  logic        rd_valid, intr;

  logic [31:0] pd16;
  logic        wr16, rd16, vld16, intr16;
  logic [1:0]  off16;
  logic [31:0] wd16, rdd16;

  logic [7:0]  pd4;
  logic        wr4, rd4, vld4, intr4;
  logic [1:0]  off4;
  logic [31:0] wd4, rdd4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nv_nvdla_glb_icx u_dut (
    .nvdla_core_clk (clk),      .nvdla_core_rstn (rstn),
    .done_intr_pd   (pd),       .reg_wr_en       (wr_en),
    .reg_rd_en      (rd_en),    .reg_offset      (off),
    .reg_wr_data    (wdata),    .reg_rd_data     (rd_data),
    .reg_rd_valid   (rd_valid), .core_intr       (intr)
  );

  nv_nvdla_glb_icx #(.NUM_CH(16)) u_dut16 (
    .nvdla_core_clk (clk),   .nvdla_core_rstn (rstn),
    .done_intr_pd   (pd16),  .reg_wr_en       (wr16),
    .reg_rd_en      (rd16),  .reg_offset      (off16),
    .reg_wr_data    (wd16),  .reg_rd_data     (rdd16),
    .reg_rd_valid   (vld16), .core_intr       (intr16)
  );

  nv_nvdla_glb_icx #(.NUM_CH(4)) u_dut4 (
    .nvdla_core_clk (clk),  .nvdla_core_rstn (rstn),
    .done_intr_pd   (pd4),  .reg_wr_en       (wr4),
    .reg_rd_en      (rd4),  .reg_offset      (off4),
    .reg_wr_data    (wd4),  .reg_rd_data     (rdd4),
    .reg_rd_valid   (vld4), .core_intr       (intr4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] o, input logic [31:0] d);
    off = o; wdata = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] o, input logic [31:0] exp);
    off = o; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk({nm, "_vld"}, 32'(rd_valid), 32'd1);
    chk(nm, rd_data, exp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();
  endtask

  typedef struct {
    logic [1:0]  woff;
    logic [31:0] wdat;
    logic [1:0]  roff;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  // Reference model state (8 channels -> 16 bits)
  logic [15:0] m_status, m_mask;
  int          m_thr, m_tmo;
  int          m_phase;   // 0 quiet, 1 gathering, 2 raised
  int          m_events, m_age;
  logic [15:0] r_pd, r_w1c, r_set, r_ns;
  logic [31:0] r_wd, r_exp_rd;
  logic [1:0]  r_off;
  logic        r_wr, r_rd, m_pend, m_rise;
  int          old_events;

  initial begin
    pd = '0; wr_en = 0; rd_en = 0; off = '0; wdata = '0;
    pd16 = '0; wr16 = 0; rd16 = 0; off16 = '0; wd16 = '0;
    pd4 = '0; wr4 = 0; rd4 = 0; off4 = '0; wd4 = '0;

    tbl[0]  = '{MASK,   32'hFFFF_FFFF, MASK,   32'h0000_FFFF};
    tbl[1]  = '{MASK,   32'h1234_5A5A, MASK,   32'h0000_5A5A};
    tbl[2]  = '{COAL,   32'hFFFF_FFFF, COAL,   32'h00FF_FFFF};
    tbl[3]  = '{COAL,   32'hABCD_1234, COAL,   32'h00CD_1234};
    tbl[4]  = '{SET,    32'h0000_0020, SET,    32'h0000_0000};
    tbl[5]  = '{STATUS, 32'h0000_0000, STATUS, 32'h0000_0020};
    tbl[6]  = '{STATUS, 32'h0000_0020, STATUS, 32'h0000_0000};
    tbl[7]  = '{SET,    32'hFFFF_0001, STATUS, 32'h0000_0001};
    tbl[8]  = '{STATUS, 32'hFFFF_FFFE, STATUS, 32'h0000_0001};
    tbl[9]  = '{STATUS, 32'hFFFF_FFFF, STATUS, 32'h0000_0000};
    tbl[10] = '{MASK,   32'hFFFF_FFFF, MASK,   32'h0000_FFFF};
    tbl[11] = '{COAL,   32'h0000_0001, COAL,   32'h0000_0001};

    // Reset values
    rstn = 1'b0;
    repeat (3) step();
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_vld", 32'(rd_valid), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    rstn = 1'b1;
    step();
    rd_chk("rst_mask", MASK, 32'h0000_FFFF);
    rd_chk("rst_status", STATUS, 32'h0);
    rd_chk("rst_coal", COAL, 32'h0000_0001);
    rd_chk("rst_set", SET, 32'h0);

    // Basic path: pulse -> status -> interrupt, W1C drops it
    wr(MASK, 32'h0);
    pd = 16'h0001; step(); pd = '0;
    chk("basic_intr_early", 32'(intr), 32'd0);
    step();
    chk("basic_intr_up", 32'(intr), 32'd1);
    rd_chk("basic_status", STATUS, 32'h1);
    wr(STATUS, 32'h1);
    step();
    chk("basic_intr_w1c", 32'(intr), 32'd0);

    // Event threshold 3, no timeout
    wr(COAL, 32'h0000_0003);
    pd = 16'h0004; step(); pd = '0; chk("thr_a", 32'(intr), 32'd0);
    step();                         chk("thr_b", 32'(intr), 32'd0);
    pd = 16'h0010; step(); pd = '0; chk("thr_c", 32'(intr), 32'd0);
    step();                         chk("thr_d", 32'(intr), 32'd0);
    pd = 16'h0040; step(); pd = '0; chk("thr_e", 32'(intr), 32'd0);
    step();                         chk("thr_fire", 32'(intr), 32'd1);
    wr(STATUS, 32'hFFFF_FFFF);
    step();
    chk("thr_clear", 32'(intr), 32'd0);

    // Timeout 10 with unreachable threshold 8
    wr(COAL, 32'h0000_0A08);
    pd = 16'h0001; step(); pd = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("tmo_wait%0d", k), 32'(intr), 32'd0);
    end
    step();
    chk("tmo_fire", 32'(intr), 32'd1);
    rd_chk("tmo_status", STATUS, 32'h1);
    wr(STATUS, 32'hFFFF_FFFF);
    step();
    chk("tmo_clear", 32'(intr), 32'd0);

    // Set beats same-cycle W1C; software SET
    wr(COAL, 32'h1);
    wr(SET, 32'h8);
    pd = 16'h0008; off = STATUS; wdata = 32'h8; wr_en = 1'b1;
    step();
    pd = '0; wr_en = 1'b0;
    rd_chk("set_wins", STATUS, 32'h8);
    wr(SET, 32'h20);
    rd_chk("sw_set", STATUS, 32'h28);
    rd_chk("set_reads0", SET, 32'h0);
    wr(STATUS, 32'hFFFF_FFFF);
    repeat (2) step();

    // Masking while firing
    pd = 16'h0002; step(); pd = '0;
    step();
    chk("mask_pre", 32'(intr), 32'd1);
    wr(MASK, 32'hFFFF_FFFF);
    rd_chk("mask_status_kept", STATUS, 32'h2);
    chk("mask_intr_off", 32'(intr), 32'd0);
    wr(MASK, 32'h0);
    step();
    chk("unmask_intr_on", 32'(intr), 32'd1);

    // Same-cycle read and write return the old value
    off = MASK; wdata = 32'h00F0; wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_old", rd_data, 32'h0);
    rd_chk("rw_new", MASK, 32'h00F0);

    // Asynchronous reset drops the interrupt immediately
    chk("prerst_intr", 32'(intr), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_intr", 32'(intr), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
    rd_chk("postrst_status", STATUS, 32'h0);

    // Register vectors
    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].woff, tbl[i].wdat);
      rd_chk($sformatf("vec%0d", i), tbl[i].roff, tbl[i].exp);
    end

    // Other channel-count builds
    pd16 = 32'h8000_0000; step(); pd16 = '0;
    off16 = STATUS; rd16 = 1'b1; step(); rd16 = 1'b0;
    chk("ch16_status", rdd16, 32'h8000_0000);
    off4 = MASK; wd4 = 32'hFFFF_FFFF; wr4 = 1'b1; step(); wr4 = 1'b0;
    rd4 = 1'b1; step(); rd4 = 1'b0;
    chk("ch4_mask", rdd4, 32'h0000_00FF);

    // Randomized run against the reference model
    do_reset();
    m_status = '0; m_mask = '1; m_thr = 1; m_tmo = 0;
    m_phase = 0; m_events = 0; m_age = 0;
    for (int n = 0; n < 3000; n++) begin
      r_pd  = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      r_wr  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 2) == 0);
      r_off = 2'($urandom_range(0, 3));
      case (r_off)
        MASK:    r_wd = $urandom & $urandom;
        COAL:    r_wd = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 6) << 8)
                        | 32'($urandom_range(0, 4));
        default: r_wd = $urandom;
      endcase

      // Read sees register contents from before this edge
      case (r_off)
        MASK:    r_exp_rd = {16'h0, m_mask};
        STATUS:  r_exp_rd = {16'h0, m_status};
        COAL:    r_exp_rd = {8'h0, 16'(m_tmo), 8'(m_thr)};
        default: r_exp_rd = 32'h0;
      endcase

      r_w1c  = (r_wr && r_off == STATUS) ? r_wd[15:0] : 16'h0;
      r_set  = (r_wr && r_off == SET) ? r_wd[15:0] : 16'h0;
      r_ns   = (m_status & ~r_w1c) | r_pd | r_set;
      m_pend = (m_status & ~m_mask) != 0;
      m_rise = (r_ns & ~m_status & ~m_mask) != 0;
      old_events = m_events;

      if (!m_pend) begin
        m_phase  = 0;
        m_events = m_rise ? 1 : 0;
        m_age    = 0;
      end else begin
        if (m_rise) m_events = (m_events + 1 > 255) ? 255 : m_events + 1;
        if (m_phase == 0) begin
          if (m_thr <= 1) m_phase = 2;
          else begin
            m_phase = 1;
            m_age   = (m_tmo != 0) ? 1 : 0;
          end
        end else if (m_phase == 1) begin
          if (old_events >= m_thr || (m_tmo != 0 && m_age == m_tmo)) m_phase = 2;
          else m_age = (m_age + 1 < m_tmo) ? m_age + 1 : m_tmo;
        end
      end
      m_status = r_ns;
      if (r_wr && r_off == MASK) m_mask = r_wd[15:0];
      if (r_wr && r_off == COAL) begin
        m_thr = int'(r_wd[7:0]);
        m_tmo = int'(r_wd[23:8]);
      end

      pd = r_pd; wr_en = r_wr; rd_en = r_rd; off = r_off; wdata = r_wd;
      step();
      pd = '0; wr_en = 1'b0; rd_en = 1'b0;
      chk($sformatf("rand_intr@%0d", n), 32'(intr), (m_phase == 2) ? 32'd1 : 32'd0);
      if (r_rd) chk($sformatf("rand_rd@%0d", n), rd_data, r_exp_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
